// File: rtl/multi_digit_display_if.sv
// Value/display bus between the meter-control FSM (master) and the
// multiplexed 7-segment driver (slave).
// Optional macro: DISPLAY_DP_EN adds the per-digit decimal-point mask and
// the decimal-point segment output.
interface multi_digit_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 16
);
  logic [BIN_W-1:0]      Bin_In;
  logic                  Load;
  logic                  Blank_En;
  logic                  Blink;
  logic                  Busy;
  logic [NUM_DIGITS-1:0] Actv_Sel;
  logic [6:0]            Dspl_Out;
`ifdef DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0] Dp_Mask;
  logic                  Dspl_Dp;

  modport master (
    output Bin_In, Load, Blank_En, Blink, Dp_Mask,
    input  Busy, Actv_Sel, Dspl_Out, Dspl_Dp
  );
  modport slave (
    input  Bin_In, Load, Blank_En, Blink, Dp_Mask,
    output Busy, Actv_Sel, Dspl_Out, Dspl_Dp
  );
`else
  modport master (
    output Bin_In, Load, Blank_En, Blink,
    input  Busy, Actv_Sel, Dspl_Out
  );
  modport slave (
    input  Bin_In, Load, Blank_En, Blink,
    output Busy, Actv_Sel, Dspl_Out
  );
`endif
endinterface

// File: rtl/multi_digit_display.sv
// N-digit multiplexed 7-segment driver for the parking-meter datapath.
// A sequential double-dabble engine turns the binary value into BCD, which is
// committed to the display register in one step; a scan engine then walks the
// digits with leading-zero blanking, whole-display blink and an overflow "E".
// Optional macro: DISPLAY_DP_EN enables the decimal-point mask/output.
module multi_digit_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 16,
  parameter int REFRESH_DIV = 3333,
  parameter int BLINK_DIV   = 15000
) (
  input  logic                SYS_CLK,
  input  logic                RESET_N,
  multi_digit_display_if.slave bus
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int ITER_W = 5;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0110000;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  conv_state_t           state;
  logic                  busy;
  logic [BIN_W-1:0]      captured;
  logic [BIN_W-1:0]      shift_reg;
  logic [BCD_W-1:0]      scratch;
  logic [BCD_W-1:0]      adjusted;
  logic [ITER_W-1:0]     iter;
  logic [BCD_W-1:0]      disp_reg;
  logic                  overflow;

  logic [REF_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  phase_on;

  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic [3:0]            cur_code;
  logic                  digit_blanked;
  logic [NUM_DIGITS-1:0] actv_sel;
  logic [6:0]            dspl_out;

  // BCD correction for the current SHIFT step.
  always_comb begin
    adjusted = dabble_adjust(scratch);
  end

  // Converter FSM: capture on Load, shift BIN_W times, then commit atomically.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      busy      <= 1'b0;
      captured  <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      iter      <= '0;
      disp_reg  <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Load) begin
            captured  <= bus.Bin_In;
            shift_reg <= bus.Bin_In;
            scratch   <= '0;
            iter      <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= {adjusted[BCD_W-2:0], shift_reg[BIN_W-1]};
          shift_reg <= shift_reg << 1;
          if (iter == ITER_W'(BIN_W - 1)) state <= DONE;
          else                            iter  <= iter + ITER_W'(1);
        end
        DONE: begin
          disp_reg <= scratch;
          overflow <= (64'(captured) > MAX_VAL);
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Refresh divider steps the digit index; each index wrap advances the blink timer.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      phase_on    <= 1'b1;
    end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
        digit_idx <= '0;
        if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          phase_on  <= ~phase_on;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end else begin
        digit_idx <= digit_idx + IDX_W'(1);
      end
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  // Mark digits whose own nibble and every more significant nibble are zero.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_reg[4*i +: 4] == 4'd0);
      if (i != 0) lead_zero[i] = zero_run;
    end
    cur_code      = disp_reg[4*digit_idx +: 4];
    digit_blanked = !overflow && bus.Blank_En && lead_zero[digit_idx];
  end

  // Registered anode/cathode drive for the digit currently selected.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      actv_sel <= '1;
      dspl_out <= SEG_BLANK;
    end else if (bus.Blink && !phase_on) begin
      actv_sel <= '1;
      dspl_out <= SEG_BLANK;
    end else begin
      actv_sel <= ~(NUM_DIGITS'(1) << digit_idx);
      if (overflow)           dspl_out <= SEG_E;
      else if (digit_blanked) dspl_out <= SEG_BLANK;
      else                    dspl_out <= seg_decode(cur_code);
    end
  end

`ifdef DISPLAY_DP_EN
  logic dspl_dp;

  // Decimal point follows the mask, dark when blinked off or lead-blanked.
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N)                         dspl_dp <= 1'b1;
    else if (bus.Blink && !phase_on)      dspl_dp <= 1'b1;
    else if (digit_blanked)               dspl_dp <= 1'b1;
    else                                  dspl_dp <= ~bus.Dp_Mask[digit_idx];
  end

  assign bus.Dspl_Dp = dspl_dp;
`endif

  assign bus.Busy     = busy;
  assign bus.Actv_Sel = actv_sel;
  assign bus.Dspl_Out = dspl_out;

endmodule

// File: tb/tb_multi_digit_display.sv
// Self-checking bench for multi_digit_display with short refresh/blink
// dividers. Expected scans are pushed to a scoreboard when a value is
// loaded and popped when the displayed scan is captured.
module tb_multi_digit_display;

  localparam int NUM_DIGITS  = 4;
  localparam int BIN_W       = 16;
  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 2;
  localparam int SCAN_CYC    = NUM_DIGITS * REFRESH_DIV;
  localparam int SCAN_W      = 7 * NUM_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0110000;

  logic SYS_CLK;
  logic RESET_N;

  multi_digit_display_if #(.NUM_DIGITS(NUM_DIGITS), .BIN_W(BIN_W)) bus ();

  multi_digit_display #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W),
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .SYS_CLK(SYS_CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [SCAN_W-1:0] sb[$];

  // Free-running 100 MHz clock.
  initial begin
    SYS_CLK = 1'b0;
    forever #5 SYS_CLK = ~SYS_CLK;
  end

  // Hard stop so a hung DUT cannot stall the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Reference model: segment pattern of every digit, digit 0 in the low bits.
  function automatic logic [SCAN_W-1:0] expected_scan(input int unsigned v, input bit blank);
    logic [SCAN_W-1:0] r;
    int unsigned       limit;
    int unsigned       div;
    int unsigned       d;
    bit                zr;
    limit = 1;
    for (int i = 0; i < NUM_DIGITS; i++) limit = limit * 10;
    zr = 1'b1;
    r  = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      div = 1;
      for (int k = 0; k < i; k++) div = div * 10;
      d  = (v / div) % 10;
      zr = zr && (d == 0);
      if (v >= limit)                 r[i*7 +: 7] = SEG_E;
      else if (blank && zr && i != 0) r[i*7 +: 7] = SEG_BLANK;
      else                            r[i*7 +: 7] = seg_of(int'(d));
    end
    return r;
  endfunction

  // One-cycle Load strobe, driven from a falling edge.
  task automatic do_load(input int unsigned value, input bit blank);
    bus.Blank_En = blank;
    bus.Bin_In   = BIN_W'(value);
    bus.Load     = 1'b1;
    @(negedge SYS_CLK);
    bus.Load     = 1'b0;
  endtask

  // Count falling edges with Busy high until it drops (bounded).
  task automatic wait_busy_fall(output int cycles, output bit timeout);
    cycles = 0;
    while (bus.Busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge SYS_CLK);
    end
    timeout = (cycles >= 200);
  endtask

  // Record the segment pattern shown for each digit over one full scan.
  task automatic capture_scan(output logic [SCAN_W-1:0] got, output bit ok);
    bit seen [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sel;
    got = '1;
    for (int d = 0; d < NUM_DIGITS; d++) seen[d] = 1'b0;
    repeat (2) @(negedge SYS_CLK);
    for (int c = 0; c < SCAN_CYC; c++) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        sel = ~(NUM_DIGITS'(1) << d);
        if (bus.Actv_Sel === sel) begin
          got[d*7 +: 7] = bus.Dspl_Out;
          seen[d]       = 1'b1;
        end
      end
      @(negedge SYS_CLK);
    end
    ok = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) ok = ok && seen[d];
  endtask

  task automatic test_reset();
    logic [NUM_DIGITS-1:0] seq[$];
    logic [NUM_DIGITS-1:0] last;
    logic [NUM_DIGITS-1:0] exp_seq [5];
    logic [NUM_DIGITS-1:0] obs;
    logic [SCAN_W-1:0]     got, exp;
    bit                    ok;
    RESET_N = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    n_cmp++;
    if (bus.Busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.Busy);
    end
    n_cmp++;
    if (bus.Actv_Sel !== 4'b1111) begin
      n_fail++; $display("[TB] FAIL reset_actv_sel: got %b expected 1111", bus.Actv_Sel);
    end
    n_cmp++;
    if (bus.Dspl_Out !== 7'b1111111) begin
      n_fail++; $display("[TB] FAIL reset_dspl_out: got %b expected 1111111", bus.Dspl_Out);
    end
    RESET_N = 1'b1;
    last = bus.Actv_Sel;
    for (int c = 0; c < 24; c++) begin
      @(negedge SYS_CLK);
      if (bus.Actv_Sel !== last) seq.push_back(bus.Actv_Sel);
      last = bus.Actv_Sel;
    end
    exp_seq[0] = 4'b1110; exp_seq[1] = 4'b1101; exp_seq[2] = 4'b1011;
    exp_seq[3] = 4'b0111; exp_seq[4] = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      obs = (i < seq.size()) ? seq[i] : 4'bxxxx;
      n_cmp++;
      if (obs !== exp_seq[i]) begin
        n_fail++; $display("[TB] FAIL scan_order[%0d]: got %b expected %b", i, obs, exp_seq[i]);
      end
    end
    bus.Blank_En = 1'b0;
    sb.push_back(expected_scan(0, 1'b0));
    capture_scan(got, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || got !== exp) begin
      n_fail++; $display("[TB] FAIL reset_zero_noblank: got %h expected %h", got, exp);
    end
    bus.Blank_En = 1'b1;
    sb.push_back(expected_scan(0, 1'b1));
    capture_scan(got, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || got !== exp) begin
      n_fail++; $display("[TB] FAIL reset_zero_blank: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_conversion();
    int unsigned       vals [2];
    bit                blanks [2];
    int                cyc;
    bit                to;
    logic [SCAN_W-1:0] got, exp;
    bit                ok;
    vals[0] = 1234; blanks[0] = 1'b0;
    vals[1] = 9999; blanks[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      sb.push_back(expected_scan(vals[t], blanks[t]));
      do_load(vals[t], blanks[t]);
      wait_busy_fall(cyc, to);
      n_cmp++;
      if (to || cyc != BIN_W + 1) begin
        n_fail++; $display("[TB] FAIL busy_len_%0d: got %0d cycles expected %0d", vals[t], cyc, BIN_W + 1);
      end
      capture_scan(got, ok);
      exp = sb.pop_front();
      n_cmp++;
      if (!ok || got !== exp) begin
        n_fail++; $display("[TB] FAIL convert_%0d: got %h expected %h", vals[t], got, exp);
      end
    end
  endtask

  task automatic test_blanking();
    int                cyc;
    bit                to;
    logic [SCAN_W-1:0] got, exp;
    bit                ok;
    sb.push_back(expected_scan(45, 1'b1));
    do_load(45, 1'b1);
    wait_busy_fall(cyc, to);
    capture_scan(got, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (to || !ok || got !== exp) begin
      n_fail++; $display("[TB] FAIL blank_45: got %h expected %h", got, exp);
    end
    bus.Blank_En = 1'b0;
    sb.push_back(expected_scan(45, 1'b0));
    capture_scan(got, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || got !== exp) begin
      n_fail++; $display("[TB] FAIL live_blank_off_45: got %h expected %h", got, exp);
    end
    sb.push_back(expected_scan(405, 1'b1));
    do_load(405, 1'b1);
    wait_busy_fall(cyc, to);
    capture_scan(got, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (to || !ok || got !== exp) begin
      n_fail++; $display("[TB] FAIL blank_inner_zero_405: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_overflow();
    int unsigned       vals [2];
    bit                blanks [2];
    int                cyc;
    bit                to;
    logic [SCAN_W-1:0] got, exp;
    bit                ok;
    vals[0] = 10000; blanks[0] = 1'b0;
    vals[1] = 65535; blanks[1] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      sb.push_back(expected_scan(vals[t], blanks[t]));
      do_load(vals[t], blanks[t]);
      wait_busy_fall(cyc, to);
      capture_scan(got, ok);
      exp = sb.pop_front();
      n_cmp++;
      if (to || !ok || got !== exp) begin
        n_fail++; $display("[TB] FAIL overflow_%0d: got %h expected %h", vals[t], got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int                cyc;
    bit                to;
    logic [SCAN_W-1:0] got, exp;
    bit                ok;
    sb.push_back(expected_scan(567, 1'b0));
    do_load(567, 1'b0);
    repeat (2) @(negedge SYS_CLK);
    bus.Bin_In = BIN_W'(8888);
    bus.Load   = 1'b1;
    @(negedge SYS_CLK);
    bus.Load   = 1'b0;
    wait_busy_fall(cyc, to);
    n_cmp++;
    if (to || cyc != BIN_W + 1 - 3) begin
      n_fail++; $display("[TB] FAIL ignored_load_busy: got %0d cycles expected %0d", cyc, BIN_W + 1 - 3);
    end
    capture_scan(got, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || got !== exp) begin
      n_fail++; $display("[TB] FAIL ignored_load_value: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_load_on_fall();
    int                cyc;
    bit                to;
    logic [SCAN_W-1:0] got, exp;
    bit                ok;
    do_load(77, 1'b0);
    wait_busy_fall(cyc, to);
    sb.push_back(expected_scan(42, 1'b0));
    do_load(42, 1'b0);
    n_cmp++;
    if (to || bus.Busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL load_on_fall_accept: got busy %b expected 1", bus.Busy);
    end
    wait_busy_fall(cyc, to);
    n_cmp++;
    if (to || cyc != BIN_W + 1) begin
      n_fail++; $display("[TB] FAIL load_on_fall_busy: got %0d cycles expected %0d", cyc, BIN_W + 1);
    end
    capture_scan(got, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || got !== exp) begin
      n_fail++; $display("[TB] FAIL load_on_fall_value: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_blink();
    int off_cnt, bad_seg, bad_sel, run, max_run;
    bit legal;
    bus.Blink = 1'b1;
    @(negedge SYS_CLK);
    off_cnt = 0; bad_seg = 0; bad_sel = 0; run = 0; max_run = 0;
    for (int c = 0; c < 8 * SCAN_CYC; c++) begin
      @(negedge SYS_CLK);
      if (bus.Actv_Sel === 4'b1111) begin
        off_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (bus.Dspl_Out !== SEG_BLANK) bad_seg++;
      end else begin
        run = 0;
        legal = (bus.Actv_Sel === 4'b1110) || (bus.Actv_Sel === 4'b1101) ||
                (bus.Actv_Sel === 4'b1011) || (bus.Actv_Sel === 4'b0111);
        if (!legal) bad_sel++;
      end
    end
    n_cmp++;
    if (off_cnt != 4 * SCAN_CYC) begin
      n_fail++; $display("[TB] FAIL blink_off_cycles: got %0d expected %0d", off_cnt, 4 * SCAN_CYC);
    end
    n_cmp++;
    if (max_run != BLINK_DIV * SCAN_CYC) begin
      n_fail++; $display("[TB] FAIL blink_off_run: got %0d expected %0d", max_run, BLINK_DIV * SCAN_CYC);
    end
    n_cmp++;
    if (bad_seg != 0) begin
      n_fail++; $display("[TB] FAIL blink_off_segments: got %0d lit cycles expected 0", bad_seg);
    end
    n_cmp++;
    if (bad_sel != 0) begin
      n_fail++; $display("[TB] FAIL blink_on_onehot: got %0d bad cycles expected 0", bad_sel);
    end
    bus.Blink = 1'b0;
    repeat (2) @(negedge SYS_CLK);
    off_cnt = 0;
    for (int c = 0; c < 4 * SCAN_CYC; c++) begin
      @(negedge SYS_CLK);
      if (bus.Actv_Sel === 4'b1111) off_cnt++;
    end
    n_cmp++;
    if (off_cnt != 0) begin
      n_fail++; $display("[TB] FAIL blink_disabled: got %0d dark cycles expected 0", off_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int                busy_cnt;
    logic [SCAN_W-1:0] got, exp;
    bit                ok;
    do_load(1234, 1'b0);
    repeat (4) @(negedge SYS_CLK);
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (bus.Busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_mid_busy: got %b expected 0", bus.Busy);
    end
    n_cmp++;
    if (bus.Actv_Sel !== 4'b1111) begin
      n_fail++; $display("[TB] FAIL reset_mid_actv_sel: got %b expected 1111", bus.Actv_Sel);
    end
    @(negedge SYS_CLK);
    RESET_N = 1'b1;
    sb.push_back(expected_scan(0, 1'b0));
    capture_scan(got, ok);
    exp = sb.pop_front();
    n_cmp++;
    if (!ok || got !== exp) begin
      n_fail++; $display("[TB] FAIL reset_mid_cleared: got %h expected %h", got, exp);
    end
    busy_cnt = 0;
    for (int c = 0; c < 2 * BIN_W; c++) begin
      @(negedge SYS_CLK);
      if (bus.Busy !== 1'b0) busy_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 0) begin
      n_fail++; $display("[TB] FAIL reset_mid_idle: got %0d busy cycles expected 0", busy_cnt);
    end
  endtask

  // Test sequence.
  initial begin
    RESET_N      = 1'b0;
    bus.Bin_In   = '0;
    bus.Load     = 1'b0;
    bus.Blank_En = 1'b0;
    bus.Blink    = 1'b0;
`ifdef DISPLAY_DP_EN
    bus.Dp_Mask  = '0;
`endif
    @(negedge SYS_CLK);
    test_reset();
    test_conversion();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_load_on_fall();
    test_blink();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
